// File: rtl/uart_rx_checked_pkg.sv
// Shared UART definitions: FSM state encodings, frame width and the mid-bit count helper.
// The transmitter uses the same encodings.
package uart_rx_checked_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    s_IDLE    = 3'd0,
    s_START   = 3'd1,
    s_DATA    = 3'd2,
    s_STOP    = 3'd3,
    s_CLEANUP = 3'd4,
    s_BREAK   = 3'd5
  } uart_state_t;

  // Count reached in START when the sample point sits at the centre of the start bit.
  function automatic logic [15:0] mid_bit_count(input int clks_per_bit);
    return 16'((clks_per_bit - 1) / 2);
  endfunction

endpackage

// File: rtl/uart_rx_checked_if.sv
// Byte-side bundle of the UART receiver: serial pin in, received byte and status pulses out.
interface uart_rx_checked_if;
  import uart_rx_checked_pkg::*;

  logic        rx_serial;
  logic        rx_dv;
  logic [7:0]  rx_byte;
  logic        rx_active;
  logic        frame_err;
  uart_state_t state;

  // rx_dv is a one-cycle valid with no ready: the consumer must take rx_byte in the cycle
  // rx_dv is high, because nothing is buffered. rx_byte stays put until the next rx_dv.
  modport master (
    output rx_serial,
    input  rx_dv, rx_byte, rx_active, frame_err, state
  );

  modport slave (
    input  rx_serial,
    output rx_dv, rx_byte, rx_active, frame_err, state
  );

endinterface

// File: rtl/uart_rx_checked_sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous bit, with a selectable reset level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_checked.sv
// UART receiver (8N1, LSB first) with input synchronizer, centred sampling,
// false-start rejection and framing-error detection with break handling.
module uart_rx_checked
  import uart_rx_checked_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic               i_Clock,
  input  logic               i_Rst_n,
  uart_rx_checked_if.slave   rx
);

  localparam logic [15:0] HALF_CNT = mid_bit_count(CLKS_PER_BIT);
  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LAST_IDX = 3'(UART_DATA_BITS - 1);

  logic rx_s;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (i_Clock),
    .rst_n (i_Rst_n),
    .d     (rx.rx_serial),
    .q     (rx_s)
  );

  uart_state_t state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  idx, idx_n;
  logic [7:0]  shreg, shreg_n;
  logic [7:0]  byte_r, byte_n;
  logic        dv_r, dv_n;
  logic        fe_r, fe_n;
  logic        active_r, active_n;

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      state    <= s_IDLE;
      cnt      <= '0;
      idx      <= '0;
      shreg    <= '0;
      byte_r   <= '0;
      dv_r     <= 1'b0;
      fe_r     <= 1'b0;
      active_r <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      shreg    <= shreg_n;
      byte_r   <= byte_n;
      dv_r     <= dv_n;
      fe_r     <= fe_n;
      active_r <= active_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt + 16'd1;
    idx_n    = idx;
    shreg_n  = shreg;
    byte_n   = byte_r;
    dv_n     = 1'b0;
    fe_n     = 1'b0;
    active_n = active_r;

    unique case (state)
      s_IDLE: begin
        cnt_n = '0;
        if (!rx_s) begin
          state_n  = s_START;
          active_n = 1'b1;
        end
      end

      // A start bit that is no longer low at its centre is treated as line noise.
      s_START: begin
        if (cnt == HALF_CNT) begin
          cnt_n = '0;
          if (!rx_s) begin
            state_n = s_DATA;
            idx_n   = '0;
          end else begin
            state_n  = s_IDLE;
            active_n = 1'b0;
          end
        end
      end

      s_DATA: begin
        if (cnt == LAST_CNT) begin
          cnt_n          = '0;
          shreg_n[idx]   = rx_s;
          if (idx == LAST_IDX) begin
            state_n = s_STOP;
          end else begin
            idx_n = idx + 3'd1;
          end
        end
      end

      s_STOP: begin
        if (cnt == LAST_CNT) begin
          cnt_n    = '0;
          active_n = 1'b0;
          if (rx_s) begin
            byte_n  = shreg;
            dv_n    = 1'b1;
            state_n = s_CLEANUP;
          end else begin
            fe_n    = 1'b1;
            state_n = s_BREAK;
          end
        end
      end

      s_CLEANUP: begin
        cnt_n   = '0;
        state_n = s_IDLE;
      end

      // Wait out a held-low line so a break yields one error instead of a stream of frames.
      s_BREAK: begin
        cnt_n = '0;
        if (rx_s) begin
          state_n = s_IDLE;
        end
      end

      default: begin
        cnt_n    = '0;
        state_n  = s_IDLE;
        active_n = 1'b0;
      end
    endcase
  end

  assign rx.rx_dv     = dv_r;
  assign rx.rx_byte   = byte_r;
  assign rx.rx_active = active_r;
  assign rx.frame_err = fe_r;
  assign rx.state     = state;

endmodule

// File: tb/tb_uart_rx_checked.sv
// Bench for uart_rx_checked: directed frames plus random traffic at 16 clocks/bit,
// and a second instance at 87 clocks/bit for nominal and +/-3% baud frames.
module tb_uart_rx_checked;
  import uart_rx_checked_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_checked_if bus16 ();
  uart_rx_checked_if bus87 ();

  uart_rx_checked #(.CLKS_PER_BIT(16)) dut16 (
    .i_Clock (clk),
    .i_Rst_n (rst_n),
    .rx      (bus16)
  );

  uart_rx_checked #(.CLKS_PER_BIT(87)) dut87 (
    .i_Clock (clk),
    .i_Rst_n (rst_n),
    .rx      (bus87)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;

  logic [7:0] exp16_q[$];
  logic [7:0] exp87_q[$];
  logic [7:0] got16_q[$];
  logic [7:0] got87_q[$];
  int         t16_q[$];
  int         t87_q[$];
  int         fe16_cnt = 0;
  int         fe87_cnt = 0;
  int         exp_fe16 = 0;
  int         dv_with_active = 0;
  int         dv_fe_both = 0;
  logic       act_seen16 = 1'b0;

  // Monitor: collects everything the DUTs report, sampled away from the active edge.
  always @(negedge clk) begin
    if (bus16.rx_dv) begin
      got16_q.push_back(bus16.rx_byte);
      t16_q.push_back(cyc);
      if (bus16.rx_active) dv_with_active++;
    end
    if (bus87.rx_dv) begin
      got87_q.push_back(bus87.rx_byte);
      t87_q.push_back(cyc);
      if (bus87.rx_active) dv_with_active++;
    end
    if (bus16.frame_err) fe16_cnt++;
    if (bus87.frame_err) fe87_cnt++;
    if ((bus16.rx_dv && bus16.frame_err) || (bus87.rx_dv && bus87.frame_err)) dv_fe_both++;
    if (bus16.rx_active) act_seen16 = 1'b1;
  end

  // ---------------- check helper ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_line(input int which, input logic v);
    if (which == 16) bus16.rx_serial = v;
    else             bus87.rx_serial = v;
  endtask

  task automatic hold(input int which, input logic v, input int n);
    set_line(which, v);
    repeat (n) @(negedge clk);
  endtask

  // Sends start, 8 data bits LSB first, and the given stop level, each 'period' clocks long.
  // If rst_bit names a data bit, reset is pulsed for one cycle in the middle of that bit.
  task automatic send_frame(input int which, input int period, input logic [7:0] b,
                            input logic stop_bit, input int rst_bit);
    hold(which, 1'b0, period);
    for (int i = 0; i < 8; i++) begin
      if (i == rst_bit) begin
        set_line(which, b[i]);
        repeat (period / 2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_dv",     32'(bus16.rx_dv),     32'd0);
        check("rst_mid_fe",     32'(bus16.frame_err), 32'd0);
        check("rst_mid_active", 32'(bus16.rx_active), 32'd0);
        check("rst_mid_byte",   32'(bus16.rx_byte),   32'h00);
        check("rst_mid_state",  32'(bus16.state),     32'(s_IDLE));
        rst_n = 1'b1;
        repeat (period - period / 2 - 1) @(negedge clk);
      end else begin
        hold(which, b[i], period);
      end
    end
    hold(which, stop_bit, period);
    set_line(which, 1'b1);
  endtask

  // Compares received bytes with the expected queue in order, then empties both.
  task automatic drain(input int which, input string tag);
    if (which == 16) begin
      check({tag, "_count"}, 32'(got16_q.size()), 32'(exp16_q.size()));
      while (got16_q.size() > 0 && exp16_q.size() > 0)
        check({tag, "_byte"}, 32'(got16_q.pop_front()), 32'(exp16_q.pop_front()));
      got16_q.delete(); exp16_q.delete(); t16_q.delete();
    end else begin
      check({tag, "_count"}, 32'(got87_q.size()), 32'(exp87_q.size()));
      while (got87_q.size() > 0 && exp87_q.size() > 0)
        check({tag, "_byte"}, 32'(got87_q.pop_front()), 32'(exp87_q.pop_front()));
      got87_q.delete(); exp87_q.delete(); t87_q.delete();
    end
  endtask

  // Reference for pin-edge-to-DV latency, from the frame timing rules.
  function automatic int exp_latency(input int cpb);
    return 2 + (cpb - 1) / 2 + 9 * cpb + 2;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int t0;
    int d;
    logic [7:0] b;
    logic err;

    bus16.rx_serial = 1'b1;
    bus87.rx_serial = 1'b1;
    repeat (4) @(negedge clk);
    check("reset_dv",     32'(bus16.rx_dv),     32'd0);
    check("reset_fe",     32'(bus16.frame_err), 32'd0);
    check("reset_active", 32'(bus16.rx_active), 32'd0);
    check("reset_byte",   32'(bus16.rx_byte),   32'h00);
    check("reset_state",  32'(bus16.state),     32'(s_IDLE));
    rst_n = 1'b1;
    hold(16, 1'b1, 20);

    // Test 1: single frame 0xA5, latency and Active timing
    t0 = cyc;
    send_frame(16, 16, 8'hA5, 1'b1, -1);
    exp16_q.push_back(8'hA5);
    hold(16, 1'b1, 16);
    if (t16_q.size() > 0) begin
      d = t16_q[0] - t0;
      check("t1_latency_window", 32'(d >= exp_latency(16) - 1 && d <= exp_latency(16) + 1), 32'd1);
    end else begin
      check("t1_dv_seen", 32'd0, 32'd1);
    end
    check("t1_active_at_dv", 32'(dv_with_active), 32'd0);
    check("t1_active_after", 32'(bus16.rx_active), 32'd0);
    check("t1_fe", 32'(fe16_cnt), 32'(exp_fe16));
    drain(16, "t1");

    // Test 2: back-to-back 0x00 then 0xFF, DVs one frame apart
    send_frame(16, 16, 8'h00, 1'b1, -1);
    send_frame(16, 16, 8'hFF, 1'b1, -1);
    exp16_q.push_back(8'h00);
    exp16_q.push_back(8'hFF);
    hold(16, 1'b1, 16);
    if (t16_q.size() >= 2) check("t2_dv_spacing", 32'(t16_q[1] - t16_q[0]), 32'd160);
    else                   check("t2_dv_pulses", 32'(t16_q.size()), 32'd2);
    drain(16, "t2");

    // Test 3: 5-cycle low glitch is rejected
    act_seen16 = 1'b0;
    hold(16, 1'b0, 5);
    hold(16, 1'b1, 32);
    check("t3_active_pulsed", 32'(act_seen16), 32'd1);
    check("t3_active_now",    32'(bus16.rx_active), 32'd0);
    check("t3_state",         32'(bus16.state), 32'(s_IDLE));
    check("t3_fe",            32'(fe16_cnt), 32'(exp_fe16));
    drain(16, "t3");

    // Test 4: framing error then held break, one error pulse, byte held
    send_frame(16, 16, 8'h3C, 1'b0, -1);
    exp_fe16++;
    hold(16, 1'b0, 48);
    hold(16, 1'b1, 16);
    check("t4_fe_once", 32'(fe16_cnt), 32'(exp_fe16));
    check("t4_byte_held", 32'(bus16.rx_byte), 32'hFF);
    drain(16, "t4_nodv");
    send_frame(16, 16, 8'h55, 1'b1, -1);
    exp16_q.push_back(8'h55);
    hold(16, 1'b1, 16);
    drain(16, "t4_recover");

    // Test 5: reset during data bit 4 aborts the frame
    send_frame(16, 16, 8'hF3, 1'b1, 4);
    hold(16, 1'b1, 16);
    drain(16, "t5_aborted");
    send_frame(16, 16, 8'h81, 1'b1, -1);
    exp16_q.push_back(8'h81);
    hold(16, 1'b1, 16);
    drain(16, "t5_recover");

    // Random traffic: random bytes, random gaps, occasional bad stop bit
    for (int r = 0; r < 10; r++) begin
      b   = 8'($urandom_range(0, 255));
      err = ($urandom_range(0, 4) == 0);
      send_frame(16, 16, b, !err, -1);
      if (err) begin
        exp_fe16++;
        hold(16, 1'b0, 16 * $urandom_range(0, 2));
        hold(16, 1'b1, 16 + $urandom_range(0, 20));
      end else begin
        exp16_q.push_back(b);
        hold(16, 1'b1, $urandom_range(0, 20));
      end
    end
    hold(16, 1'b1, 32);
    check("rand_fe", 32'(fe16_cnt), 32'(exp_fe16));
    drain(16, "rand");

    // Test 6: 87 clocks/bit, nominal then 3% short and 3% long bit periods
    hold(87, 1'b1, 87);
    t0 = cyc;
    send_frame(87, 87, 8'h96, 1'b1, -1);
    exp87_q.push_back(8'h96);
    hold(87, 1'b1, 87);
    if (t87_q.size() > 0) begin
      d = t87_q[0] - t0;
      check("t6_latency_window", 32'(d >= exp_latency(87) - 1 && d <= exp_latency(87) + 1), 32'd1);
    end else begin
      check("t6_dv_seen", 32'd0, 32'd1);
    end
    send_frame(87, 84, 8'h96, 1'b1, -1);
    exp87_q.push_back(8'h96);
    hold(87, 1'b1, 87);
    send_frame(87, 90, 8'h96, 1'b1, -1);
    exp87_q.push_back(8'h96);
    hold(87, 1'b1, 87);
    check("t6_fe", 32'(fe87_cnt), 32'd0);
    drain(87, "t6");

    check("dv_fe_exclusive", 32'(dv_fe_both), 32'd0);
    check("dv_active_overlap", 32'(dv_with_active), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
